// File: rtl/acc_uart_tx.sv
// acc_uart_tx: watches the datapath accumulator value and transmits every
// new value as a UART frame (8N1 by default) through a small FIFO.
// Optional feature: define ACC_UART_PARITY_EN to insert an even-parity bit
// between the data bits and the stop bit (8E1, 11 bit-times per frame).
module acc_uart_tx #(
  parameter int CLKS_PER_BIT = 16,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic [7:0]                    data_in,
  output logic                          tx,
  output logic                          busy,
  output logic [$clog2(FIFO_DEPTH):0]   fifo_count,
  output logic                          fifo_full,
  output logic                          overflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [15:0]      BAUD_LAST = 16'(CLKS_PER_BIT - 1);
  localparam logic [CNT_W-1:0] DEPTH_C   = CNT_W'(FIFO_DEPTH);

  localparam logic [2:0] IDLE   = 3'd0;
  localparam logic [2:0] START  = 3'd1;
  localparam logic [2:0] DATA   = 3'd2;
  localparam logic [2:0] STOP   = 3'd4;
`ifdef ACC_UART_PARITY_EN
  localparam logic [2:0] PARITY = 3'd3;
`endif

  logic [7:0]       shadow;
  logic [7:0]       mem [FIFO_DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;
  logic [7:0]       shreg;
  logic [2:0]       state;
  logic [15:0]      baud;
  logic [2:0]       bit_idx;
  logic             change;
  logic             baud_done;
  logic             pop;
  logic             push;
`ifdef ACC_UART_PARITY_EN
  logic             par_bit;
`endif

  assign fifo_full  = (count == DEPTH_C);
  assign fifo_count = count;
  assign busy       = (state != IDLE);

  // Change detection, FIFO handshake and transmitter pop decision.
  always_comb begin
    change    = (data_in != shadow);
    baud_done = (baud == BAUD_LAST);
    // Pop when idle, or on the final stop cycle so frames run back to back.
    pop       = (count != '0) && ((state == IDLE) || ((state == STOP) && baud_done));
    // A pop at the same edge frees a slot, so a full FIFO can still accept.
    push      = change && (!fifo_full || pop);
  end

  // Shadow register tracks the last accepted value; overflow is sticky.
  always_ff @(posedge clk) begin
    if (rst) begin
      shadow   <= 8'h00;
      overflow <= 1'b0;
    end else if (change) begin
      shadow <= data_in;
      if (!push) overflow <= 1'b1;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally at FIFO_DEPTH.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

  // FIFO storage; contents are meaningful only between the pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= data_in;
  end

  // Shift register holds the byte on the line; it never stays in the FIFO.
  always_ff @(posedge clk) begin
    if (pop) begin
      shreg <= mem[rd_ptr];
    end else if ((state == DATA) && baud_done) begin
      shreg <= shreg >> 1;
    end
  end

`ifdef ACC_UART_PARITY_EN
  // Even parity of the popped byte, captured alongside the shift register.
  always_ff @(posedge clk) begin
    if (pop) par_bit <= ^mem[rd_ptr];
  end
`endif

  // Transmit FSM; tx is registered so the line never glitches from inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state   <= IDLE;
      tx      <= 1'b1;
      baud    <= 16'd0;
      bit_idx <= 3'd0;
    end else begin
      case (state)
        IDLE: begin
          baud <= 16'd0;
          tx   <= 1'b1;
          if (pop) begin
            state <= START;
            tx    <= 1'b0;
          end
        end
        START: begin
          if (baud_done) begin
            baud    <= 16'd0;
            bit_idx <= 3'd0;
            state   <= DATA;
            tx      <= shreg[0];
          end else begin
            baud <= baud + 16'd1;
          end
        end
        DATA: begin
          if (baud_done) begin
            baud <= 16'd0;
            if (bit_idx == 3'd7) begin
`ifdef ACC_UART_PARITY_EN
              state <= PARITY;
              tx    <= par_bit;
`else
              state <= STOP;
              tx    <= 1'b1;
`endif
            end else begin
              bit_idx <= bit_idx + 3'd1;
              // Next bit is shreg[1] because the shift happens at this edge.
              tx      <= shreg[1];
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
`ifdef ACC_UART_PARITY_EN
        PARITY: begin
          if (baud_done) begin
            baud  <= 16'd0;
            state <= STOP;
            tx    <= 1'b1;
          end else begin
            baud <= baud + 16'd1;
          end
        end
`endif
        STOP: begin
          if (baud_done) begin
            baud <= 16'd0;
            if (pop) begin
              state <= START;
              tx    <= 1'b0;
            end else begin
              state <= IDLE;
              tx    <= 1'b1;
            end
          end else begin
            baud <= baud + 16'd1;
          end
        end
        default: begin
          state <= IDLE;
          tx    <= 1'b1;
          baud  <= 16'd0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_acc_uart_tx.sv
// Testbench for acc_uart_tx: frame-level reference model checked every
// cycle, a line decoder, and directed scenarios with literal expectations.
module tb_acc_uart_tx;

  localparam int CPB   = 4;
  localparam int DEPTH = 4;
`ifdef ACC_UART_PARITY_EN
  localparam int NBITS = 11;
`else
  localparam int NBITS = 10;
`endif

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [7:0] data_in = 8'h00;
  logic       tx, busy, fifo_full, overflow;
  logic [2:0] fifo_count;

  acc_uart_tx #(.CLKS_PER_BIT(CPB), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk), .rst(rst), .data_in(data_in), .tx(tx), .busy(busy),
    .fifo_count(fifo_count), .fifo_full(fifo_full), .overflow(overflow)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;
  bit chk_en = 1'b0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a byte queue plus the list of line levels still to send.
  logic [7:0] m_shadow = 8'h00;
  logic [7:0] m_q[$];
  bit         m_line[$];
  logic       m_tx = 1'b1;
  logic       m_busy = 1'b0;
  logic       m_ovf = 1'b0;

  always @(posedge clk) begin : model
    logic [7:0] b;
    if (rst) begin
      m_shadow = 8'h00;
      m_q.delete();
      m_line.delete();
      m_tx   = 1'b1;
      m_busy = 1'b0;
      m_ovf  = 1'b0;
    end else begin
      if (m_line.size() == 0) begin
        if (m_q.size() > 0) begin
          b = m_q.pop_front();
          for (int k = 0; k < CPB; k++) m_line.push_back(1'b0);
          for (int i = 0; i < 8; i++)
            for (int k = 0; k < CPB; k++) m_line.push_back(b[i]);
`ifdef ACC_UART_PARITY_EN
          for (int k = 0; k < CPB; k++) m_line.push_back(($countones(b) % 2) == 1);
`endif
          for (int k = 0; k < CPB; k++) m_line.push_back(1'b1);
          m_tx   = m_line.pop_front();
          m_busy = 1'b1;
        end else begin
          m_tx   = 1'b1;
          m_busy = 1'b0;
        end
      end else begin
        m_tx   = m_line.pop_front();
        m_busy = 1'b1;
      end
      if (data_in != m_shadow) begin
        if (m_q.size() < DEPTH) m_q.push_back(data_in);
        else m_ovf = 1'b1;
        m_shadow = data_in;
      end
    end
  end

  // Per-cycle comparison of every output against the model.
  always @(negedge clk) begin
    if (chk_en) begin
      check("tx", tx, m_tx);
      check("busy", busy, m_busy);
      check("fifo_count", fifo_count, m_q.size());
      check("fifo_full", fifo_full, m_q.size() == DEPTH);
      check("overflow", overflow, m_ovf);
    end
  end

  // Activity counters used by the directed scenarios.
  int   busy_cyc = 0;
  int   busy_fall = 0;
  int   peak = 0;
  logic busy_prev = 1'b0;
  always @(negedge clk) begin
    if (chk_en) begin
      if (busy === 1'b1) busy_cyc++;
      if (busy_prev === 1'b1 && busy === 1'b0) busy_fall++;
      busy_prev = busy;
      if (int'(fifo_count) > peak) peak = int'(fifo_count);
    end
  end

  // Line decoder: samples each bit mid-way, abandons a frame on reset.
  logic [7:0] rx_q[$];
  bit         rx_par_q[$];
  bit         rx_act = 1'b0;
  int         rx_cnt = 0;
  logic [7:0] rx_sh = 8'h00;
  always @(negedge clk) begin : rxdec
    int k;
    if (rst) begin
      rx_act = 1'b0;
    end else if (!rx_act) begin
      if (tx === 1'b0) begin
        rx_act = 1'b1;
        rx_cnt = 0;
      end
    end else begin
      rx_cnt++;
      if (rx_cnt % CPB == CPB / 2) begin
        k = rx_cnt / CPB;
        if (k == NBITS - 1) begin
          check("rx_stop_bit", tx, 1'b1);
          rx_q.push_back(rx_sh);
          rx_act = 1'b0;
        end else if (k >= 1 && k <= 8) begin
          rx_sh[k-1] = tx;
        end else if (k == 9) begin
          rx_par_q.push_back(tx);
        end
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic wait_idle(input int maxc, input string name);
    int c = 0;
    while ((busy !== 1'b0 || fifo_count !== 3'd0) && c < maxc) begin
      tick(1);
      c++;
    end
    check(name, c < maxc, 1'b1);
    tick(2);
  endtask

  logic       s [NBITS*CPB];
  logic [10:0] pat;

  initial begin
    // Reset idle.
    rst = 1'b1;
    data_in = 8'h00;
    @(posedge clk);
    #1 chk_en = 1'b1;
    tick(2);
    rst = 1'b0;
    @(negedge clk);
    check("rst_tx", tx, 1'b1);
    check("rst_busy", busy, 1'b0);
    check("rst_count", fifo_count, 3'd0);
    check("rst_ovf", overflow, 1'b0);
    busy_cyc = 0;
    tick(100);
    check("idle_busy_cycles", busy_cyc, 0);
    check("idle_rx_frames", rx_q.size(), 0);

    // Single byte A5: two-edge latency, then the literal line pattern.
`ifdef ACC_UART_PARITY_EN
    pat = 11'b10101001010;
`else
    pat = 11'b01101001010;
`endif
    rx_q.delete();
    data_in = 8'hA5;
    @(posedge clk);
    @(negedge clk);
    check("a5_e0_tx", tx, 1'b1);
    check("a5_e0_count", fifo_count, 3'd1);
    @(posedge clk);
    @(negedge clk);
    check("a5_e1_tx_low", tx, 1'b0);
    for (int i = 0; i < NBITS * CPB; i++) begin
      s[i] = tx;
      @(negedge clk);
    end
    for (int b = 0; b < NBITS; b++)
      check("a5_line_bit", {s[4*b+3], s[4*b+2], s[4*b+1], s[4*b]}, {4{pat[b]}});
    check("a5_busy_after", busy, 1'b0);
    check("a5_rx_count", rx_q.size(), 1);
    check("a5_rx_byte", rx_q[0], 8'hA5);

    // Back-to-back 01, 02, 03.
    tick(1);
    rx_q.delete();
    peak = 0;
    busy_fall = 0;
    busy_cyc = 0;
    data_in = 8'h01;
    tick(1);
    data_in = 8'h02;
    tick(1);
    data_in = 8'h03;
    wait_idle(400, "b2b_timeout");
    check("b2b_rx_count", rx_q.size(), 3);
    check("b2b_rx0", rx_q[0], 8'h01);
    check("b2b_rx1", rx_q[1], 8'h02);
    check("b2b_rx2", rx_q[2], 8'h03);
    check("b2b_peak", peak, 2);
    check("b2b_no_gap", busy_fall, 1);
    check("b2b_busy_cycles", busy_cyc, 3 * NBITS * CPB);

    // Overflow: one frame on the line, six more values, two dropped.
    rx_q.delete();
    data_in = 8'h10;
    tick(3);
    for (int i = 1; i <= 6; i++) begin
      data_in = 8'h10 + 8'(i);
      tick(1);
    end
    check("ovf_set", overflow, 1'b1);
    check("ovf_full", fifo_full, 1'b1);
    wait_idle(800, "ovf_timeout");
    check("ovf_sticky", overflow, 1'b1);
    check("ovf_rx_count", rx_q.size(), 5);
    for (int i = 0; i < 5; i++) check("ovf_rx_byte", rx_q[i], 8'h10 + 8'(i));
    rst = 1'b1;
    data_in = 8'h00;
    tick(1);
    rst = 1'b0;
    check("ovf_cleared", overflow, 1'b0);

    // Reset during data bit 3 of FF, then a clean 3C.
    tick(2);
    rx_q.delete();
    data_in = 8'hFF;
    begin
      int c = 0;
      while (tx !== 1'b0 && c < 20) begin
        tick(1);
        c++;
      end
      check("ff_start_seen", c < 20, 1'b1);
    end
    tick(17);
    check("ff_bit3_high", tx, 1'b1);
    check("ff_busy_mid", busy, 1'b1);
    rst = 1'b1;
    data_in = 8'h3C;
    tick(1);
    check("midrst_tx", tx, 1'b1);
    check("midrst_busy", busy, 1'b0);
    check("midrst_count", fifo_count, 3'd0);
    rst = 1'b0;
    tick(3);
    wait_idle(400, "3c_timeout");
    check("3c_rx_count", rx_q.size(), 1);
    check("3c_rx_byte", rx_q[0], 8'h3C);

    // Frame length for 07, and parity bits when configured.
    rx_q.delete();
    rx_par_q.delete();
    busy_cyc = 0;
    data_in = 8'h07;
    tick(3);
    wait_idle(400, "07_timeout");
    check("07_rx_byte", rx_q[0], 8'h07);
`ifdef ACC_UART_PARITY_EN
    check("07_frame_len", busy_cyc, 44);
    check("07_parity", rx_par_q[0], 1'b1);
`else
    check("07_frame_len", busy_cyc, 40);
`endif
    data_in = 8'h03;
    tick(3);
    wait_idle(400, "03_timeout");
    check("03_rx_byte", rx_q[1], 8'h03);
`ifdef ACC_UART_PARITY_EN
    check("03_parity", rx_par_q[1], 1'b0);
`endif

    tick(2);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish at %0t", $time);
    $fatal(1);
  end

endmodule
